core4_led_pwm_driver: RTL and testbench
=======================================

// Module: core4_led_pwm_driver
// PURPOSE
//  Downstream consumer of the green-LED PIO: takes the PIO's 8-bit out_port and drives the board LEDs.
//  Adds global PWM dimming, optional blinking and polarity inversion.
//  Has its own small Avalon-MM slave so software can set brightness and blink rate without touching the LED data path.
// PARAMETERS
//  PRESCALE      16      clocks per PWM tick (>=2); PWM frame = 256*PRESCALE clocks
//  DUTY_RST      8'hFF   reset value of DUTY (0xFF = full on)
//  BLINK_RST     16'h100 reset value of BLINK_HALF (frames per blink half-period)
// PORTS
//  clk         in   1   system clock
//  reset_n     in   1   synchronous reset, active-low
//  led_in      in   8   LED pattern from green-LED PIO out_port
//  address     in   2   slave register select
//  chipselect  in   1   slave select
//  write_n     in   1   write strobe, active-low
//  writedata   in   32  write data
//  readdata    out  32  read data, combinational, zero-extended
//  led_out     out  8   registered drive to board LEDs
// BEHAVIOUR
//  Clocking: one clock. Reset is synchronous and active-low, sampled on posedge clk.
//    While reset_n=0: all registers and counters load their reset values. led_out=8'h00 from the next edge.
//  Registers (write when chipselect & ~write_n):
//    addr0 CONTROL [2:0]   bit0 enable, bit1 blink_en, bit2 invert; reset 3'b001
//    addr1 DUTY    [7:0]   writes go to duty_shadow (reset DUTY_RST); readback returns shadow
//    addr2 BLINK_HALF[15:0]; reset BLINK_RST
//    addr3 STATUS  RO      bit0 blink_phase, [15:8] led_q; writes ignored
//  Prescaler: counts 0..PRESCALE-1; tick=1 when count==PRESCALE-1, then wraps to 0.
//  PWM counter pwm_cnt[7:0]: increments on tick and wraps 255->0.
//    frame_end = tick & (pwm_cnt==255).
//  Duty shadowing: active_duty <= duty_shadow on frame_end only.
//    A DUTY write on the frame_end cycle is seen from the following frame.
//  pwm_on = (active_duty==8'hFF) | (pwm_cnt < active_duty).
//    Duty 0 gives constant off. Duty 0xFF gives constant on (no 1/256 gap).
//  Blink: blink_cnt[15:0] counts frame_ends.
//    When blink_cnt==BLINK_HALF-1 on a frame_end: toggle blink_phase and clear blink_cnt.
//    BLINK_HALF==0 forces blink_phase=1 and blink_cnt=0.
//    Any BLINK_HALF write clears blink_cnt and sets blink_phase=1.
//    blink_phase reset value is 1.
//  Data path: led_q <= led_in every cycle.
//    gate = pwm_on & (blink_phase | ~blink_en)
//    led_out <= enable ? ((led_q & {8{gate}}) ^ {8{invert}}) : {8{invert}}
//    Latency from led_in to led_out: 2 clocks.
//  Readdata: mux on address, same cycle, independent of chipselect; unused upper bits 0.
//  Counters are not affected by register writes except as stated above; wrap-around is modular.
// TESTING
//  1 Reset release, led_in=8'hA5 -> led_out=8'hA5 two clocks later.
//    Readback: addr0=1, addr1=0xFF, addr2=0x100, addr3=0x0001|(A5<<8).
//  2 PRESCALE=4, DUTY=0x40 -> per 1024-clock frame, led_out=led_in for 256 clocks, then 0x00.
//    DUTY write mid-frame -> old duty holds until next frame_end.
//  3 DUTY=0x00 -> led_out stays 0x00 across 3 frames. DUTY=0xFF -> led_out constant =led_in.
//  4 BLINK_HALF=2, CONTROL=3'b011, DUTY=0xFF -> led_in shown 2 frames, 0x00 for 2 frames, repeating.
//    BLINK_HALF=0 -> steady on.
//  5 CONTROL=3'b100 -> led_out=0xFF.
//    CONTROL=3'b101, led_in=0x0F, DUTY=0xFF -> led_out=0xF0.
//  6 reset_n low mid-frame with LEDs lit -> led_out=0x00 after next edge.
//    On release, prescaler and PWM restart at 0 and registers return to defaults.

Source files
------------

// File: rtl/core4_led_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module  : core4_led_pwm_driver
// Brief   : Drives board LEDs from the green-LED PIO with global PWM dimming,
//           optional blinking and polarity inversion; small Avalon-MM slave.
// Revision: 1.0 - initial release
// ============================================================================
module core4_led_pwm_driver #(
    parameter int          PRESCALE  = 16,
    parameter logic [7:0]  DUTY_RST  = 8'hFF,
    parameter logic [15:0] BLINK_RST = 16'h0100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  led_in,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  led_out
);

    localparam int            PS_W    = $clog2(PRESCALE);
    localparam logic [PS_W-1:0] C_PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] pre_q;
    logic [7:0]      pwm_cnt_q;
    logic [7:0]      duty_shadow_q;
    logic [7:0]      active_duty_q;
    logic [2:0]      ctrl_q;
    logic [15:0]     blink_half_q;
    logic [15:0]     blink_cnt_q;
    logic [15:0]     blink_cnt_d;
    logic            blink_phase_q;
    logic            blink_phase_d;
    logic [7:0]      led_q;
    logic [7:0]      led_out_q;
    logic [7:0]      led_out_d;

    logic w_wr;
    logic w_tick;
    logic w_frame_end;
    logic w_pwm_on;
    logic w_gate;
    logic unused_wdata;

    assign w_wr        = chipselect & ~write_n;
    assign w_tick      = (pre_q == C_PS_LAST);
    assign w_frame_end = w_tick & (pwm_cnt_q == 8'hFF);
    // Full scale is special-cased so 0xFF has no one-step dark gap per frame
    assign w_pwm_on    = (active_duty_q == 8'hFF) | (pwm_cnt_q < active_duty_q);
    assign w_gate      = w_pwm_on & (blink_phase_q | ~ctrl_q[1]);
    assign unused_wdata = ^writedata[31:16];

    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if ((w_wr && address == 2'd2) || blink_half_q == 16'd0) begin
            blink_cnt_d   = 16'd0;
            blink_phase_d = 1'b1;
        end else if (w_frame_end) begin
            if (blink_cnt_q == blink_half_q - 16'd1) begin
                blink_cnt_d   = 16'd0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        led_out_d = ctrl_q[0] ? ((led_q & {8{w_gate}}) ^ {8{ctrl_q[2]}}) : {8{ctrl_q[2]}};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pre_q         <= '0;
            pwm_cnt_q     <= 8'd0;
            duty_shadow_q <= DUTY_RST;
            active_duty_q <= DUTY_RST;
            ctrl_q        <= 3'b001;
            blink_half_q  <= BLINK_RST;
            blink_cnt_q   <= 16'd0;
            blink_phase_q <= 1'b1;
            led_q         <= 8'h00;
            led_out_q     <= 8'h00;
        end else begin
            pre_q <= w_tick ? '0 : pre_q + 1'b1;
            if (w_tick) begin
                pwm_cnt_q <= pwm_cnt_q + 8'd1;
            end
            // Frame-boundary reload keeps each PWM frame at a single duty
            if (w_frame_end) begin
                active_duty_q <= duty_shadow_q;
            end
            if (w_wr && address == 2'd0) begin
                ctrl_q <= writedata[2:0];
            end
            if (w_wr && address == 2'd1) begin
                duty_shadow_q <= writedata[7:0];
            end
            if (w_wr && address == 2'd2) begin
                blink_half_q <= writedata[15:0];
            end
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            led_q         <= led_in;
            led_out_q     <= led_out_d;
        end
    end

    always_comb begin
        readdata = 32'd0;
        case (address)
            2'd0:    readdata = {29'd0, ctrl_q};
            2'd1:    readdata = {24'd0, duty_shadow_q};
            2'd2:    readdata = {16'd0, blink_half_q};
            default: readdata = {16'd0, led_q, 7'd0, blink_phase_q};
        endcase
    end

    assign led_out = led_out_q;

endmodule
`default_nettype wire

// File: tb/tb_core4_led_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module  : tb_core4_led_pwm_driver
// Brief   : Scoreboard bench with a frame-arithmetic reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_core4_led_pwm_driver;

    localparam int P     = 4;
    localparam int FRAME = 256 * P;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  led_in = 8'h00;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [7:0]  led_out;

    core4_led_pwm_driver #(.PRESCALE(P)) dut (
        .clk(clk), .reset_n(reset_n), .led_in(led_in), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(readdata), .led_out(led_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: time since reset, frames since last blink restart
    int          m_cyc = 0;
    int          m_n   = 0;
    logic [2:0]  m_ctrl = 3'b001;
    logic [7:0]  m_shadow = 8'hFF;
    logic [7:0]  m_active = 8'hFF;
    logic [15:0] m_half = 16'h0100;
    logic [7:0]  m_lq = 8'h00;

    logic [7:0]  sb_q[$];
    logic [31:0] rd_q[$];
    event        rd_ev;
    bit          rand_led = 1'b0;

    function automatic logic m_phase();
        if (m_half == 16'd0) return 1'b1;
        return ((m_n / int'(m_half)) % 2) == 0;
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return {29'd0, m_ctrl};
            2'd1:    return {24'd0, m_shadow};
            2'd2:    return {16'd0, m_half};
            default: return {16'd0, m_lq, 7'd0, m_phase()};
        endcase
    endfunction

    initial begin
        logic [7:0] exp;
        int         pwm;
        logic       on, gate, fe, wr;
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                exp = 8'h00;
                m_cyc = 0; m_n = 0; m_ctrl = 3'b001; m_shadow = 8'hFF;
                m_active = 8'hFF; m_half = 16'h0100; m_lq = 8'h00;
            end else begin
                pwm  = (m_cyc / P) % 256;
                on   = (m_active == 8'hFF) || (pwm < int'(m_active));
                gate = on && (m_phase() || !m_ctrl[1]);
                exp  = m_ctrl[0] ? ((m_lq & {8{gate}}) ^ {8{m_ctrl[2]}}) : {8{m_ctrl[2]}};
                fe   = (m_cyc % FRAME) == FRAME - 1;
                wr   = chipselect && !write_n;
                if (fe) m_active = m_shadow;
                if (wr && address == 2'd0) m_ctrl = writedata[2:0];
                if (wr && address == 2'd1) m_shadow = writedata[7:0];
                if (wr && address == 2'd2) begin
                    m_half = writedata[15:0];
                    m_n = 0;
                end else if (fe) begin
                    m_n++;
                end
                m_cyc++;
                m_lq = led_in;
            end
            sb_q.push_back(exp);
        end
    end

    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_checks++;
                if (led_out !== e) begin
                    n_fail++;
                    $display("FAIL led_out: got %h expected %h at %0t", led_out, e, $time);
                end
            end
        end
    end

    initial begin
        logic [31:0] e;
        forever begin
            @(rd_ev);
            #1;
            e = rd_q.pop_front();
            n_checks++;
            if (readdata !== e) begin
                n_fail++;
                $display("FAIL readdata[%0d]: got %h expected %h at %0t", address, readdata, e, $time);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rand_led) led_in = 8'($urandom);
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'($urandom);
    endtask

    task automatic bus_read(input logic [1:0] a);
        @(negedge clk);
        address = a;
        #1;
        rd_q.push_back(m_read(a));
        ->rd_ev;
    endtask

    task automatic read_all();
        for (int i = 0; i < 4; i++) bus_read(2'(i));
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (cycles) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    function automatic logic [31:0] rand_wdata(input logic [1:0] a);
        logic [31:0] r;
        r = $urandom;
        case (a)
            2'd0: return {r[31:3], r[2:1], (r[5:4] != 2'b00)};
            2'd1: case (r[9:8])
                      2'd0: return {r[31:8], 8'h00};
                      2'd1: return {r[31:8], 8'h40};
                      2'd2: return {r[31:8], 8'hFF};
                      default: return r;
                  endcase
            2'd2: return {r[31:16], 14'd0, r[1:0]};
            default: return r;
        endcase
    endfunction

    initial begin
        int r;
        logic [1:0] a;
        reset_n = 1'b0;
        led_in  = 8'hA5;
        idle(3);
        reset_n = 1'b1;
        idle(4);
        read_all();

        rand_led = 1'b1;
        bus_write(2'd1, 32'h40);
        idle(3000);
        bus_write(2'd1, 32'h80);
        idle(2000);
        read_all();
        bus_write(2'd1, 32'h00);
        idle(3100);
        bus_write(2'd1, 32'hFF);
        idle(1100);

        bus_write(2'd2, 32'd2);
        bus_write(2'd0, 32'd3);
        idle(5000);
        read_all();
        bus_write(2'd2, 32'd0);
        idle(1100);

        bus_write(2'd0, 32'd4);
        idle(50);
        rand_led = 1'b0;
        led_in = 8'h0F;
        bus_write(2'd0, 32'd5);
        idle(50);
        read_all();
        bus_write(2'd3, 32'hFFFF_FFFF);
        read_all();

        rand_led = 1'b1;
        bus_write(2'd0, 32'd1);
        idle(600);
        do_reset(2);
        idle(3);
        read_all();

        for (int i = 0; i < 40000; i++) begin
            r = $urandom_range(0, 9999);
            a = 2'($urandom);
            if (r < 30)        bus_write(a, rand_wdata(a));
            else if (r < 80)   bus_read(a);
            else if (r == 80)  do_reset($urandom_range(1, 3));
            else               @(negedge clk);
        end

        idle(4);
        read_all();
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
